demux_1_4_8_bit_reg_v: RTL and testbench
========================================

DEMUX_1_4_8_BIT_REG_V -- requirements
Module: demux_1_4_8_bit_reg_v

Interface
REQ-001 SHALL have port: i_clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: i_en  input  1  block enable; low blocks acceptance.
REQ-004 SHALL have port: i_valid  input  1  upstream byte valid.
REQ-005 SHALL have port: o_ready  output  1  upstream byte accepted this cycle when high with i_valid.
REQ-006 SHALL have port: i_code  input  8  upstream byte.
REQ-007 SHALL have port: i_sel_code  input  2  destination channel when i_auto=0.
REQ-008 SHALL have port: i_auto  input  1  1 = round-robin destination; 0 = i_sel_code.
REQ-009 SHALL have ports: o_code_0..o_code_3  output  8 each  per-channel held byte.
REQ-010 SHALL have port: o_valid  output  4  bit k = channel k byte pending.
REQ-011 SHALL have port: i_ready  input  4  bit k = channel k consumer takes byte.
REQ-012 SHALL have port: o_rr_ptr  output  2  current round-robin pointer.

Function
REQ-013 Destination d SHALL be o_rr_ptr when i_auto=1, else i_sel_code.
REQ-014 o_ready SHALL be combinational: i_en & (~o_valid[d] | i_ready[d]).
REQ-015 Accept SHALL occur when i_valid & o_ready; the byte is then written to o_code_d with o_valid[d]=1 on the next edge (1-cycle latency).
REQ-016 Drain of channel k SHALL occur when o_valid[k] & i_ready[k]; if no accept targets k that cycle, o_valid[k] SHALL clear next edge.
REQ-017 Simultaneous drain and accept on the same channel SHALL leave o_valid[k]=1 with new byte loaded (no bubble, no loss).
REQ-018 Non-targeted channels SHALL only drain; channels drain independently and concurrently.
REQ-019 o_code_k SHALL hold its last loaded value after drain until the next load.
REQ-020 With i_auto=1, o_rr_ptr SHALL increment by 1 per accept, wrapping 3->0; it SHALL hold when no accept or when i_auto=0.
REQ-021 If o_valid[d]=1 and i_ready[d]=0, upstream SHALL stall (o_ready=0) even if other channels are empty; no skipping.
REQ-022 i_en=0 SHALL force o_ready=0; pending channels still drain.
REQ-023 Toggling i_auto SHALL not alter o_rr_ptr.

Reset
REQ-024 On i_rst=1 at a clock edge: o_code_0..3 = 8'h00, o_valid = 4'b0000, o_rr_ptr = 2'b00.
REQ-025 Reset SHALL override any same-cycle accept or drain; pending bytes are discarded.
REQ-026 o_ready during reset SHALL follow REQ-014 from the reset-cleared state only after the edge; no accept takes effect while i_rst=1.

Structure
REQ-027 Shared package SHALL hold constants N_CH=4, CODE_W=8, SEL_W=2.
REQ-028 One sub-module demux_chan_slot_v (one-entry register: load, drain, valid, data) SHALL be instantiated N_CH times; top holds destination decode, o_ready, round-robin pointer.

Verification
REQ-029 Reset then i_auto=0, i_sel_code=2, i_code=8'hA5, i_valid=1 one cycle, i_ready=0 -> next cycle o_code_2=8'hA5, o_valid=4'b0100, others 0.
REQ-030 i_auto=1, four bytes 8'h10,8'h11,8'h12,8'h13 back-to-back, i_ready=4'hF -> each lands on channels 0,1,2,3 in order, o_rr_ptr wraps to 0 after 4th.
REQ-031 Channel 1 full, i_ready[1]=0, i_sel_code=1, i_valid=1 -> o_ready=0, o_code_1 unchanged; raise i_ready[1] -> o_ready=1 same cycle, new byte loaded, o_valid[1] stays 1.
REQ-032 i_en=0 with i_valid=1 and o_valid=4'b1001, i_ready=4'b1001 -> o_ready=0, o_valid=4'b0000 next cycle, o_code_0/o_code_3 retain values.
REQ-033 i_rst=1 asserted while i_valid=1 and o_valid=4'b1111 -> next cycle all outputs zero, o_rr_ptr=0, byte not captured.

Source files
------------

// File: rtl/demux_1_4_8_bit_reg_v_pkg.sv
// Shared constants and helpers for the 1-to-4 registered byte demultiplexer.
// Imported by the top level and by the per-channel slot.
package demux_1_4_8_bit_reg_v_pkg;

   localparam int unsigned N_CH   = 4;
   localparam int unsigned CODE_W = 8;
   localparam int unsigned SEL_W  = 2;

   // Round-robin advance; the natural SEL_W-bit wrap gives 3 -> 0.
   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
      return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/demux_1_4_8_bit_reg_v_chan_slot.sv
// One-entry output register for a single demux channel.
// A load in the same cycle as a drain keeps the slot full with the new byte.
module demux_chan_slot_v
   import demux_1_4_8_bit_reg_v_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic [CODE_W-1:0] data_i,
   output logic              valid_o,
   output logic [CODE_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [CODE_W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (drain_i) begin
         // Data is held after a drain; only the valid flag drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1_4_8_bit_reg_v.sv
// 1-to-4 byte demultiplexer with a one-entry register per channel, selectable
// fixed or round-robin destination, and per-channel valid/ready drain.
module demux_1_4_8_bit_reg_v
   import demux_1_4_8_bit_reg_v_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [CODE_W-1:0] i_code,
   input  logic [SEL_W-1:0]  i_sel_code,
   input  logic              i_auto,
   output logic [CODE_W-1:0] o_code_0,
   output logic [CODE_W-1:0] o_code_1,
   output logic [CODE_W-1:0] o_code_2,
   output logic [CODE_W-1:0] o_code_3,
   output logic [N_CH-1:0]   o_valid,
   input  logic [N_CH-1:0]   i_ready,
   output logic [SEL_W-1:0]  o_rr_ptr
);

   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [SEL_W-1:0]  dest;
   logic              accept;
   logic [N_CH-1:0]   load;
   logic [N_CH-1:0]   drain;
   logic [N_CH-1:0]   slot_valid;
   logic [CODE_W-1:0] slot_code [N_CH];

   always_comb begin
      dest     = i_auto ? rr_ptr_q : i_sel_code;
      // Strict in-order: a blocked destination stalls upstream, no skipping.
      o_ready  = i_en & (~slot_valid[dest] | i_ready[dest]);
      accept   = i_valid & o_ready;
      rr_ptr_d = (accept && i_auto) ? rr_next(rr_ptr_q) : rr_ptr_q;
      load     = '0;
      drain    = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         load[k]  = accept && (dest == k[SEL_W-1:0]);
         drain[k] = slot_valid[k] & i_ready[k];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_slot
      demux_chan_slot_v u_slot (
         .clk_i   (i_clk),
         .rst_i   (i_rst),
         .load_i  (load[g]),
         .drain_i (drain[g]),
         .data_i  (i_code),
         .valid_o (slot_valid[g]),
         .data_o  (slot_code[g])
      );
   end

   assign o_valid  = slot_valid;
   assign o_code_0 = slot_code[0];
   assign o_code_1 = slot_code[1];
   assign o_code_2 = slot_code[2];
   assign o_code_3 = slot_code[3];
   assign o_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_demux_1_4_8_bit_reg_v.sv
// Self-checking bench: array-based channel model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_demux_1_4_8_bit_reg_v;

   logic       clk = 1'b0;
   logic       rst, en, valid, auto_sel;
   logic [7:0] code;
   logic [1:0] sel;
   logic [3:0] rdy;
   logic       o_ready;
   logic [7:0] o_code_0, o_code_1, o_code_2, o_code_3;
   logic [3:0] o_valid;
   logic [1:0] o_rr_ptr;

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;

   // Behavioural model: one pending flag and held byte per channel, plus pointer.
   bit       mv [4];
   bit [7:0] mc [4];
   int       mptr;

   logic [7:0] dut_code [4];
   assign dut_code[0] = o_code_0;
   assign dut_code[1] = o_code_1;
   assign dut_code[2] = o_code_2;
   assign dut_code[3] = o_code_3;

   always #5 clk = ~clk;

   demux_1_4_8_bit_reg_v dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_valid    (valid),
      .o_ready    (o_ready),
      .i_code     (code),
      .i_sel_code (sel),
      .i_auto     (auto_sel),
      .o_code_0   (o_code_0),
      .o_code_1   (o_code_1),
      .o_code_2   (o_code_2),
      .o_code_3   (o_code_3),
      .o_valid    (o_valid),
      .i_ready    (rdy),
      .o_rr_ptr   (o_rr_ptr)
   );

   function automatic bit model_ready();
      int d;
      d = auto_sel ? mptr : int'(sel);
      return en && (!mv[d] || rdy[d]);
   endfunction

   initial begin
      for (int k = 0; k < 4; k++) begin
         mv[k] = 1'b0;
         mc[k] = 8'h00;
      end
      mptr = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0;
            mc[k] = 8'h00;
         end
         mptr = 0;
      end else begin
         int  d;
         bit  acc;
         d   = auto_sel ? mptr : int'(sel);
         acc = valid && model_ready();
         for (int k = 0; k < 4; k++) begin
            if (acc && d == k) begin
               mv[k] = 1'b1;
               mc[k] = code;
            end else if (mv[k] && rdy[k]) begin
               mv[k] = 1'b0;
            end
         end
         if (acc && auto_sel) mptr = (mptr + 1) % 4;
      end
   end

   always @(negedge clk) begin
      #2;
      if (checking) begin
         logic [3:0] ev;
         for (int k = 0; k < 4; k++) ev[k] = mv[k];
         tests++;
         if (o_ready !== model_ready()) begin
            fails++;
            $display("FAIL model_ready t=%0t got=%b exp=%b", $time, o_ready, model_ready());
         end
         tests++;
         if (o_valid !== ev) begin
            fails++;
            $display("FAIL model_valid t=%0t got=%b exp=%b", $time, o_valid, ev);
         end
         tests++;
         if (o_rr_ptr !== 2'(mptr)) begin
            fails++;
            $display("FAIL model_ptr t=%0t got=%0d exp=%0d", $time, o_rr_ptr, mptr);
         end
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (dut_code[k] !== mc[k]) begin
               fails++;
               $display("FAIL model_code%0d t=%0t got=%h exp=%h", k, $time, dut_code[k], mc[k]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic set(input bit e, input bit v, input logic [7:0] c,
                      input logic [1:0] s, input bit a, input logic [3:0] r);
      en = e; valid = v; code = c; sel = s; auto_sel = a; rdy = r;
   endtask

   initial begin
      rst = 1'b1;
      set(0, 0, 8'h00, 2'd0, 0, 4'h0);
      repeat (2) @(negedge clk);
      checking = 1'b1;
      #3;
      chk("reset_valid", {4'h0, o_valid}, 8'h00);
      chk("reset_ptr",   {6'h0, o_rr_ptr}, 8'h00);
      chk("reset_code2", o_code_2, 8'h00);

      // Fixed destination: A5 to channel 2, nobody draining.
      @(negedge clk);
      rst = 1'b0;
      set(1, 1, 8'hA5, 2'd2, 0, 4'h0);
      @(negedge clk);
      valid = 1'b0;
      #3;
      chk("sel2_code2",  o_code_2, 8'hA5);
      chk("sel2_valid",  {4'h0, o_valid}, 8'h04);
      chk("sel2_code0",  o_code_0, 8'h00);
      chk("sel2_stall",  {7'h0, o_ready}, 8'h00);

      // Drain, then round-robin 10..13 with all consumers ready.
      @(negedge clk);
      set(1, 0, 8'h00, 2'd0, 1, 4'hF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set(1, 1, 8'h10 + 8'(k), 2'd0, 1, 4'hF);
         @(negedge clk);
         valid = 1'b0;
         #3;
         chk($sformatf("rr_code%0d", k), dut_code[k], 8'h10 + 8'(k));
         chk($sformatf("rr_ptr%0d", k), {6'h0, o_rr_ptr}, 8'((k + 1) % 4));
      end

      // Channel 1 blocked: stall, then release in the same cycle as a new load.
      @(negedge clk);
      set(1, 1, 8'h55, 2'd1, 0, 4'h0);
      @(negedge clk);
      code = 8'h66;
      #1;
      chk("stall_ready", {7'h0, o_ready}, 8'h00);
      @(negedge clk);
      #3;
      chk("stall_code1", o_code_1, 8'h55);
      rdy = 4'b0010;
      #1;
      chk("release_ready", {7'h0, o_ready}, 8'h01);
      @(negedge clk);
      valid = 1'b0;
      rdy   = 4'h0;
      #3;
      chk("release_code1",  o_code_1, 8'h66);
      chk("release_valid1", {7'h0, o_valid[1]}, 8'h01);

      // Build o_valid = 1001 (drain ch1 meanwhile), then disable with drains.
      @(negedge clk);
      set(1, 1, 8'hA0, 2'd0, 0, 4'b0010);
      @(negedge clk);
      set(1, 1, 8'hB3, 2'd3, 0, 4'h0);
      @(negedge clk);
      set(0, 1, 8'hEE, 2'd0, 0, 4'b1001);
      #1;
      chk("en0_pre_valid", {4'h0, o_valid}, 8'h09);
      chk("en0_ready", {7'h0, o_ready}, 8'h00);
      @(negedge clk);
      set(1, 0, 8'h00, 2'd0, 0, 4'h0);
      #3;
      chk("en0_valid", {4'h0, o_valid}, 8'h00);
      chk("en0_code0", o_code_0, 8'hA0);
      chk("en0_code3", o_code_3, 8'hB3);

      // Fill all four, then reset while an accept is offered.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set(1, 1, 8'hC0 + 8'(k), 2'd0, 1, 4'h0);
      end
      @(negedge clk);
      set(1, 1, 8'hDD, 2'd0, 1, 4'hF);
      rst = 1'b1;
      #1;
      chk("rst_pre_valid", {4'h0, o_valid}, 8'h0F);
      @(negedge clk);
      rst = 1'b0;
      valid = 1'b0;
      #3;
      chk("rst_valid", {4'h0, o_valid}, 8'h00);
      chk("rst_ptr",   {6'h0, o_rr_ptr}, 8'h00);
      chk("rst_code0", o_code_0, 8'h00);
      chk("rst_code3", o_code_3, 8'h00);

      // Mixed traffic; the per-cycle model comparison covers these.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         set(($urandom_range(0, 7) != 0), $urandom_range(0, 1), 8'($urandom),
             2'($urandom), $urandom_range(0, 1), 4'($urandom));
         rst = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      valid = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
